// File: rtl/mem_fifo_pkg.sv
// Shared sizing and pointer helpers for the 48x64 memory-backed FIFO controller.
package mem_fifo_pkg;

    localparam int DEPTH      = 48;
    localparam int WIDTH      = 64;
    localparam int MASK_GRAN  = 8;
    localparam int OBUF_DEPTH = 3;

    localparam int ADDR_W  = 6;
    localparam int MASK_W  = WIDTH / MASK_GRAN;
    localparam int LEVEL_W = 6;
    localparam int OCNT_W  = 2;

    // DEPTH is not a power of two, so the wrap has to be explicit.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/mem_fifo_obuf.sv
// Three-entry circular output buffer that absorbs the memory's one-cycle read latency.
module mem_fifo_obuf
    import mem_fifo_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  push_data_i,
    input  logic              pop_i,
    output logic [OCNT_W-1:0] count_o,
    output logic              valid_o,
    output logic [WIDTH-1:0]  head_data_o
);

    logic [WIDTH-1:0]  data_q [OBUF_DEPTH];
    logic [OCNT_W-1:0] head_q, head_d;
    logic [OCNT_W-1:0] tail_q, tail_d;
    logic [OCNT_W-1:0] count_q, count_d;
    logic              pop_fire;

    function automatic logic [OCNT_W-1:0] slot_inc(input logic [OCNT_W-1:0] s);
        return (s == OCNT_W'(OBUF_DEPTH - 1)) ? '0 : s + OCNT_W'(1);
    endfunction

    assign pop_fire    = pop_i & (count_q != '0);
    assign count_o     = count_q;
    assign valid_o     = (count_q != '0);
    assign head_data_o = data_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = slot_inc(tail_q);
        end
        if (pop_fire) begin
            head_d = slot_inc(head_q);
        end
        case ({push_i, pop_fire})
            2'b10:   count_d = count_q + OCNT_W'(1);
            2'b01:   count_d = count_q - OCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; count_q alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            data_q[tail_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mem_fifo_ctrl_48x64.sv
// 48x64 FIFO controller driving a 1R1W masked memory; optional level port under MEM_FIFO_LEVEL_EN.
module mem_fifo_ctrl_48x64
    import mem_fifo_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [WIDTH-1:0]  enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [WIDTH-1:0]  deq_data,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic [WIDTH-1:0]  W0_data,
    output logic [MASK_W-1:0] W0_mask,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [WIDTH-1:0]  R0_data
`ifdef MEM_FIFO_LEVEL_EN
    ,
    output logic [LEVEL_W-1:0] level
`endif
);

    localparam logic [ADDR_W-1:0]   MCNT_FULL = ADDR_W'(DEPTH);
    localparam logic [OCNT_W:0]     OBUF_ROOM = (OCNT_W + 1)'(OBUF_DEPTH - 1);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W-1:0] mcnt_q, mcnt_d;
    logic              inflight_q, inflight_d;
    logic [OCNT_W-1:0] ocnt;
    logic              obuf_valid;
    logic              enq_fire;
    logic              issue;
    logic              deq_fire;

    assign enq_ready = reset_n & (mcnt_q < MCNT_FULL);
    assign enq_fire  = enq_valid & enq_ready;

    // Reserve a buffer slot for every outstanding read so a capture never overflows.
    assign issue = reset_n & (mcnt_q != '0)
                 & (((OCNT_W + 1)'(ocnt) + (OCNT_W + 1)'(inflight_q)) <= OBUF_ROOM);

    assign deq_valid = reset_n & obuf_valid;
    assign deq_fire  = deq_valid & deq_ready;

    assign W0_en   = enq_fire;
    assign W0_addr = wptr_q;
    assign W0_data = enq_data;
    assign W0_mask = enq_fire ? '1 : '0;
    assign R0_en   = issue;
    assign R0_addr = rptr_q;

    always_comb begin
        wptr_d     = enq_fire ? ptr_inc(wptr_q) : wptr_q;
        rptr_d     = issue ? ptr_inc(rptr_q) : rptr_q;
        inflight_d = issue;
        case ({enq_fire, issue})
            2'b10:   mcnt_d = mcnt_q + ADDR_W'(1);
            2'b01:   mcnt_d = mcnt_q - ADDR_W'(1);
            default: mcnt_d = mcnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            mcnt_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mcnt_q     <= mcnt_d;
            inflight_q <= inflight_d;
        end
    end

    mem_fifo_obuf u_obuf (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .push_i      (inflight_q),
        .push_data_i (R0_data),
        .pop_i       (deq_fire),
        .count_o     (ocnt),
        .valid_o     (obuf_valid),
        .head_data_o (deq_data)
    );

`ifdef MEM_FIFO_LEVEL_EN
    assign level = reset_n ? (LEVEL_W'(mcnt_q) + LEVEL_W'(ocnt) + LEVEL_W'(inflight_q)) : '0;
`endif

endmodule
